// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 target turning command/data frames into register strobes
// Optional feature: define SPI_ADDR_AUTOINC_EN for multi-byte frames with address auto-increment.
module spi_reg_peripheral #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rdata
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sclk_q;
    logic [2:0]          bitcnt;
    logic [DATA_W-2:0]   rx_shift;
    logic [DATA_W-1:0]   rx_byte;
    logic [DATA_W-1:0]   tx_shift;
    logic                rw;
    logic                rise;
    logic                fall;
    logic                abort;
    logic                last_bit;

    assign rise     = spi_sclk & ~sclk_q;
    assign fall     = ~spi_sclk & sclk_q;
    assign abort    = ~ena | spi_cs_n;
    assign last_bit = rise && (bitcnt == 3'(DATA_W - 1));
    // Byte as it will look once the current MOSI bit is shifted in.
    assign rx_byte  = {rx_shift, spi_mosi};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD:  if (last_bit) state_nxt = DATA;
`ifdef SPI_ADDR_AUTOINC_EN
                DATA: state_nxt = DATA;
`else
                DATA: if (last_bit) state_nxt = DONE;
`endif
                DONE: state_nxt = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_q    <= 1'b0;
            bitcnt    <= 3'd0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rw        <= 1'b0;
            spi_miso  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
        end else begin
            sclk_q    <= spi_sclk;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (abort) begin
                bitcnt   <= 3'd0;
                tx_shift <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bitcnt   <= 3'd0;
                        tx_shift <= '0;
                        spi_miso <= 1'b0;
                    end
                    CMD: begin
                        if (rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bitcnt   <= bitcnt + 3'd1;
                        end
                        if (last_bit) begin
                            rw        <= rx_byte[DATA_W-1];
                            reg_addr  <= rx_byte[ADDR_W-1:0];
                            reg_rd_en <= ~rx_byte[DATA_W-1];
                        end
                    end
                    DATA: begin
                        if (rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bitcnt   <= bitcnt + 3'd1;
                        end
                        if (last_bit) begin
                            if (rw) begin
                                reg_wr_en <= 1'b1;
                                reg_wdata <= rx_byte;
                            end
`ifdef SPI_ADDR_AUTOINC_EN
                            else begin
                                reg_addr  <= reg_addr + ADDR_W'(1);
                                reg_rd_en <= 1'b1;
                            end
`endif
                        end
`ifdef SPI_ADDR_AUTOINC_EN
                        // Step past the address only after its write strobe has been seen.
                        if (reg_wr_en) reg_addr <= reg_addr + ADDR_W'(1);
`endif
                        if (fall) begin
                            spi_miso <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    DONE: begin
                        spi_miso <= 1'b0;
                    end
                endcase
                if (reg_rd_en) tx_shift <= reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - randomized scoreboard bench for spi_reg_peripheral
module tb_spi_reg_peripheral;

    localparam int AW = 3;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          ena = 1'b1;
    logic          cs_n = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic [7:0]    reg_rdata;
    logic          reg_wr_en;
    logic          reg_rd_en;

    int            total = 0;
    int            bad = 0;
    logic [7:0]    bank_mem [8];
    logic [7:0]    ref_mem [8];
    ev_t           exp_q [$];
    ev_t           mon_e;
    ev_t           mon_a;
    logic [7:0]    fb [$];
    logic [7:0]    rxb [$];
    logic [7:0]    exp_miso [$];
    int            last_bits;
    logic [7:0]    r;

    spi_reg_peripheral #(.ADDR_W(AW), .DATA_W(8)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .spi_cs_n  (cs_n),
        .spi_sclk  (sclk),
        .spi_mosi  (mosi),
        .spi_miso  (miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    assign reg_rdata = bank_mem[reg_addr];
    always @(posedge clk) if (reg_wr_en) bank_mem[reg_addr] <= reg_wdata;

    always @(negedge clk) begin
        if (rstb && (reg_wr_en || reg_rd_en)) begin
            total++;
            if (reg_wr_en && reg_rd_en) begin
                bad++;
                $display("FAIL both_strobes wr=%0b rd=%0b required only one", reg_wr_en, reg_rd_en);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe wr=%0b addr=%0d data=%02h required none",
                         reg_wr_en, reg_addr, reg_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = '{reg_wr_en, reg_addr, (reg_wr_en ? reg_wdata : 8'h00)};
                if (mon_a !== mon_e)
                    begin
                        bad++;
                        $display("FAIL strobe got wr=%0b addr=%0d data=%02h want wr=%0b addr=%0d data=%02h",
                                 mon_a.wr, mon_a.addr, mon_a.data, mon_e.wr, mon_e.addr, mon_e.data);
                    end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference: byte 0 is {rw, addr}; each completed data byte is one register access.
    task automatic predict();
        int            n_full;
        logic          rw;
        logic [AW-1:0] a;
        logic [AW-1:0] an;
        exp_miso.delete();
        n_full = (last_bits == 8) ? fb.size() : fb.size() - 1;
        for (int k = 0; k < n_full; k++) exp_miso.push_back(8'h00);
        if (!ena || n_full == 0) return;
        rw = fb[0][7];
        a  = fb[0][AW-1:0];
        if (!rw) exp_q.push_back('{1'b0, a, 8'h00});
`ifdef SPI_ADDR_AUTOINC_EN
        for (int k = 1; k < n_full; k++) begin
            an = a + AW'(1);
            if (rw) begin
                exp_q.push_back('{1'b1, a, fb[k]});
                ref_mem[a] = fb[k];
            end else begin
                exp_miso[k] = ref_mem[a];
                exp_q.push_back('{1'b0, an, 8'h00});
            end
            a = an;
        end
`else
        an = a;
        if (n_full >= 2) begin
            if (rw) begin
                exp_q.push_back('{1'b1, an, fb[1]});
                ref_mem[an] = fb[1];
            end else begin
                exp_miso[1] = ref_mem[an];
            end
        end
`endif
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rv);
        rv = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            rv[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] rv;
        predict();
        rxb.delete();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < fb.size(); k++) begin
            send_bits(fb[k], (k == fb.size() - 1) ? last_bits : 8, rv);
            rxb.push_back(rv);
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < exp_miso.size(); k++)
            chk($sformatf("miso_byte%0d", k), {24'h0, rxb[k]}, {24'h0, exp_miso[k]});
    endtask

    task automatic frame2(input logic [7:0] c, input logic [7:0] d, input int nbits);
        fb.delete();
        fb.push_back(c);
        fb.push_back(d);
        last_bits = nbits;
        run_frame();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bank_mem[i] = 8'($urandom);
            ref_mem[i]  = bank_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 0);
        chk("rst_addr", {29'h0, reg_addr}, 0);
        chk("rst_wdata", {24'h0, reg_wdata}, 0);
        chk("rst_wr_en", {31'h0, reg_wr_en}, 0);
        chk("rst_rd_en", {31'h0, reg_rd_en}, 0);
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        frame2(8'h83, 8'hA5, 8);
        bank_mem[5] = 8'h3C;
        ref_mem[5]  = 8'h3C;
        frame2(8'h05, 8'h00, 8);
        frame2(8'h81, 8'h22, 5);
        frame2(8'h81, 8'h11, 8);

        // Reset in the middle of a read of 0xFF, while MISO is driving a 1.
        frame2(8'h86, 8'hFF, 8);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back('{1'b0, 3'd6, 8'h00});
        send_bits(8'h06, 8, r);
        send_bits(8'h00, 2, r);
        repeat (2) @(negedge clk);
        chk("miso_pre_reset", {31'h0, miso}, 1);
        #2 rstb = 1'b0;
        #1;
        chk("midrst_miso", {31'h0, miso}, 0);
        chk("midrst_addr", {29'h0, reg_addr}, 0);
        chk("midrst_wr_en", {31'h0, reg_wr_en}, 0);
        chk("midrst_rd_en", {31'h0, reg_rd_en}, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (4) @(negedge clk);
        frame2(8'h82, 8'h7E, 8);

        ena = 1'b0;
        frame2(8'h84, 8'h5A, 8);
        ena = 1'b1;

`ifdef SPI_ADDR_AUTOINC_EN
        fb.delete();
        fb.push_back(8'h87);
        fb.push_back(8'h01);
        fb.push_back(8'h02);
        fb.push_back(8'h03);
        last_bits = 8;
        run_frame();
        fb.delete();
        fb.push_back(8'h07);
        fb.push_back(8'h00);
        fb.push_back(8'h00);
        fb.push_back(8'h00);
        run_frame();
`endif

        for (int t = 0; t < 24; t++) begin
            int nb;
            nb = $urandom_range(2, 3);
            fb.delete();
            for (int j = 0; j < nb; j++) fb.push_back(8'($urandom));
            last_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
            ena = ($urandom_range(0, 7) != 0);
            run_frame();
            ena = 1'b1;
        end

        for (int i = 0; i < 8; i++) frame2(8'(i), 8'h00, 8);

        repeat (10) @(negedge clk);
        chk("pending_strobes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
